tdm_mux4_tx: RTL and testbench
==============================

// Module: tdm_mux4_tx
// PURPOSE
//  Time-division transmitter for the 4:1 demux channel. Captures a frame of
//  four W-bit words (I0..I3) and sends them one slot at a time on a single
//  bus Y, driving select lines S0/S1 alongside the data. The far-end 4:1
//  demux uses S0/S1 to route Y back onto Y0..Y3. Adds a load handshake,
//  per-slot hold timing, a frame-sync pulse and back-to-back frames.
// PARAMETERS
//  W          8   width of each channel word and of Y
//  SLOT_HOLD  1   clock cycles each slot is held on Y (legal range >= 1)
// PORTS
//  clk    in   1   system clock, rising-edge
//  rst    in   1   reset, asynchronous, active-high
//  I0     in   W   channel 0 word (sampled only on frame accept)
//  I1     in   W   channel 1 word
//  I2     in   W   channel 2 word
//  I3     in   W   channel 3 word
//  load   in   1   frame valid; accepted on a rising edge when load & ready
//  ready  out  1   transmitter can accept a frame this cycle
//  Y      out  W   serialized slot data
//  S0     out  1   select MSB to the demux (slot index bit 1)
//  S1     out  1   select LSB to the demux (slot index bit 0)
//  valid  out  1   Y/S0/S1 carry a live slot
//  sync   out  1   first cycle of slot 0 of each frame
// BEHAVIOUR
//  - Reset (async): state=IDLE, slot=0, hold=0, frame regs=0. Outputs:
//    Y=0, S0=S1=0, valid=0, sync=0, ready=0 while rst=1. ready=1 in the
//    first cycle after release.
//  - FSM states: IDLE and SEND. slot is a 2-bit counter. hold counts
//    0..SLOT_HOLD-1 and is $clog2(SLOT_HOLD)+1 bits wide.
//  - IDLE: ready=1, valid=0, Y=0, S0=S1=0. On load at an edge, latch I0..I3,
//    set slot=0 and hold=0, and go to SEND.
//  - Latency: a frame accepted at edge N shows slot 0 (valid=1, sync=1)
//    in the cycle after edge N.
//  - SEND: valid=1, Y=frame[slot], S0=slot[1], S1=slot[0]. This gives
//    slot k -> demux output Yk (slot1: S0=0,S1=1; slot2: S0=1,S1=0).
//    hold increments every cycle. When hold=SLOT_HOLD-1, hold wraps to 0
//    and slot increments.
//  - sync=1 only when state=SEND, slot=0 and hold=0.
//  - ready in SEND is 1 only on the last cycle of the frame
//    (slot=3, hold=SLOT_HOLD-1).
//  - End of frame: if load=1 at that edge, latch the new frame and continue
//    at slot=0 with no idle gap (sync asserts again). Otherwise go to IDLE.
//  - load while ready=0 is ignored (no capture, no queueing).
//  - I0..I3 changing during SEND have no effect on Y.
//  - Y, S0, S1, valid, sync and ready depend only on registered state.
//    There is no combinational path from I*/load to any output.
//  - Reset mid-frame aborts at once: outputs go to reset values within the
//    same cycle and remaining slots are lost.
//  - SLOT_HOLD=1: one slot per cycle, 4-cycle frames, ready high on every
//    slot-3 cycle.
// TESTING
//  1 Reset: rst=1 with load=1 -> ready=0, valid=0, Y=0; release ->
//    ready=1 next cycle, no frame accepted during reset.
//  2 Single frame, SLOT_HOLD=1, I0..I3=8'hA0,A1,A2,A3, load for 1 cycle ->
//    next 4 cycles give Y=A0,A1,A2,A3 with {S0,S1}=00,01,10,11; sync only
//    on the A0 cycle; then valid=0 and ready=1.
//  3 Loopback through the 4:1 demux (W=1, I=1010) -> demux Y0..Y3 pulse
//    high exactly in slots 0 and 2.
//  4 Back-to-back frames: hold load=1 with frames 11..14 then 21..24 ->
//    Y=11,12,13,14,21,22,23,24 with no gap; sync on 11 and 21; I* changes
//    mid-frame not visible.
//  5 SLOT_HOLD=3 -> each word held 3 cycles, 12-cycle frame, ready only on
//    cycle 12; load on cycle 5 ignored.
//  6 Assert rst on slot 2 -> outputs 0 at once; after release, a new load
//    restarts at slot 0 with sync=1.

Source files
------------

// File: rtl/tdm_mux4_tx_if.sv
// Bus bundle between a frame source and the 4-slot TDM transmitter.
// The source drives the frame words and load; the transmitter drives the slot bus back.
interface tdm_mux4_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] I0;
  logic [W-1:0] I1;
  logic [W-1:0] I2;
  logic [W-1:0] I3;
  logic         load;
  logic         ready;
  logic [W-1:0] Y;
  logic         S0;
  logic         S1;
  logic         valid;
  logic         sync;

  modport master (
    output I0, I1, I2, I3, load,
    input  ready, Y, S0, S1, valid, sync
  );

  modport slave (
    input  I0, I1, I2, I3, load,
    output ready, Y, S0, S1, valid, sync
  );
endinterface

// File: rtl/tdm_mux4_tx.sv
// Four-slot time-division transmitter: latches a frame of four words and sends
// them one slot at a time on Y, with demux selects, frame sync and load handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in flight; ready=1, outputs parked at zero
// SEND  | frame in flight; slot/hold walk through 4 x SLOT_HOLD cycles
module tdm_mux4_tx #(
  parameter int W         = 8,
  parameter int SLOT_HOLD = 1
) (
  input  logic          clk,
  input  logic          rst,
  tdm_mux4_tx_if.slave  bus
);

  localparam int            HW        = $clog2(SLOT_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SLOT_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [1:0]    slot;
  logic [1:0]    nxt_slot;
  logic [HW-1:0] hold;
  logic [HW-1:0] nxt_hold;
  logic [W-1:0]  frame     [4];
  logic [W-1:0]  nxt_frame [4];
  logic          accept;

  logic          ready_r;
  logic          valid_r;
  logic [W-1:0]  y_r;
  logic          s0_r;
  logic          s1_r;
  logic          sync_r;

  // Acceptance uses the registered ready, so load never reaches an output
  // combinationally and a load during the first post-reset cycle is ignored.
  always_comb begin
    nxt_state = state;
    nxt_slot  = slot;
    nxt_hold  = hold;
    nxt_frame = frame;
    accept    = ready_r & bus.load;

    if (accept) begin
      nxt_state    = SEND;
      nxt_slot     = 2'd0;
      nxt_hold     = '0;
      nxt_frame[0] = bus.I0;
      nxt_frame[1] = bus.I1;
      nxt_frame[2] = bus.I2;
      nxt_frame[3] = bus.I3;
    end else if (state == SEND) begin
      if (hold == HOLD_LAST) begin
        nxt_hold = '0;
        if (slot == 2'd3) begin
          nxt_state = IDLE;
          nxt_slot  = 2'd0;
        end else begin
          nxt_slot = slot + 2'd1;
        end
      end else begin
        nxt_hold = hold + HW'(1);
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // state/slot/hold in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= 2'd0;
      hold    <= '0;
      frame   <= '{default: '0};
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      y_r     <= '0;
      s0_r    <= 1'b0;
      s1_r    <= 1'b0;
      sync_r  <= 1'b0;
    end else begin
      state   <= nxt_state;
      slot    <= nxt_slot;
      hold    <= nxt_hold;
      frame   <= nxt_frame;
      ready_r <= (nxt_state == IDLE) ||
                 ((nxt_slot == 2'd3) && (nxt_hold == HOLD_LAST));
      valid_r <= (nxt_state == SEND);
      y_r     <= (nxt_state == SEND) ? nxt_frame[nxt_slot] : '0;
      s0_r    <= (nxt_state == SEND) & nxt_slot[1];
      s1_r    <= (nxt_state == SEND) & nxt_slot[0];
      sync_r  <= (nxt_state == SEND) && (nxt_slot == 2'd0) && (nxt_hold == '0);
    end
  end

  assign bus.ready = ready_r;
  assign bus.valid = valid_r;
  assign bus.Y     = y_r;
  assign bus.S0    = s0_r;
  assign bus.S1    = s1_r;
  assign bus.sync  = sync_r;

endmodule

// File: tb/tb_tdm_mux4_tx.sv
// Self-checking bench for tdm_mux4_tx: scoreboard of expected slots compared
// against three instances (SLOT_HOLD=1, SLOT_HOLD=3, and a 1-bit loopback).
module tb_tdm_mux4_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_mux4_tx_if #(.W(8)) bus_a ();
  tdm_mux4_tx_if #(.W(8)) bus_b ();
  tdm_mux4_tx_if #(.W(1)) bus_c ();

  tdm_mux4_tx #(.W(8), .SLOT_HOLD(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  tdm_mux4_tx #(.W(8), .SLOT_HOLD(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  tdm_mux4_tx #(.W(1), .SLOT_HOLD(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // far-end 4:1 demux model: {S0,S1} selects the output
  logic [3:0] dmx;
  always_comb begin
    dmx = 4'b0000;
    if (bus_c.valid) dmx[{bus_c.S0, bus_c.S1}] = bus_c.Y;
  end

  typedef struct {
    logic [7:0] y;
    logic [1:0] sel;
    logic       sync;
    logic       ready;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] dsb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic exp_t mk(input logic [7:0] y, input int sel, input bit s, input bit r);
    exp_t e;
    e.y = y; e.sel = 2'(sel); e.sync = s; e.ready = r;
    return e;
  endfunction

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1;
    bus_a.load = 1'b1;
    bus_a.I0 = 8'h11; bus_a.I1 = 8'h22; bus_a.I2 = 8'h33; bus_a.I3 = 8'h44;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h0) $display("FAIL reset_hold got %h want %h", got, 13'h0);
    else pass_cnt++;
    total_cnt++;
    if ({bus_b.ready, bus_b.valid, bus_c.ready, bus_c.valid} !== 4'b0000)
      $display("FAIL reset_hold_bc got %b want 0000",
               {bus_b.ready, bus_b.valid, bus_c.ready, bus_c.valid});
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h1) $display("FAIL reset_release got %h want %h", got, 13'h1);
    else pass_cnt++;
  endtask

  task automatic test_single_frame();
    exp_t e;
    logic [12:0] got, want;
    @(posedge clk); #1;
    bus_a.I0 = 8'hA0; bus_a.I1 = 8'hA1; bus_a.I2 = 8'hA2; bus_a.I3 = 8'hA3;
    bus_a.load = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(mk(8'hA0 + 8'(k), k, k == 0, k == 3));
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    bus_a.I0 = 8'h50; bus_a.I1 = 8'h51; bus_a.I2 = 8'h52; bus_a.I3 = 8'h53;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (sb.size() == 0) $display("FAIL single_frame k=%0d scoreboard empty", k);
      else begin
        e = sb.pop_front();
        want = {1'b1, e.y, e.sel, e.sync, e.ready};
        got  = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
        if (got !== want) $display("FAIL single_frame k=%0d got %h want %h", k, got, want);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h1) $display("FAIL single_frame_idle got %h want %h", got, 13'h1);
    else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [3:0] bits, want;
    bits = 4'b0101;
    @(posedge clk); #1;
    bus_c.I0 = bits[0]; bus_c.I1 = bits[1]; bus_c.I2 = bits[2]; bus_c.I3 = bits[3];
    bus_c.load = 1'b1;
    for (int k = 0; k < 4; k++) dsb.push_back(4'(bits[k]) << k);
    @(posedge clk); #1;
    bus_c.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (dsb.size() == 0) $display("FAIL loopback k=%0d scoreboard empty", k);
      else begin
        want = dsb.pop_front();
        if (dmx !== want) $display("FAIL loopback k=%0d got %b want %b", k, dmx, want);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total_cnt++;
    if (dmx !== 4'b0000) $display("FAIL loopback_idle got %b want 0000", dmx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [12:0] got, want;
    @(posedge clk); #1;
    bus_a.I0 = 8'h11; bus_a.I1 = 8'h12; bus_a.I2 = 8'h13; bus_a.I3 = 8'h14;
    bus_a.load = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(mk(8'h11 + 8'(k), k, k == 0, k == 3));
    for (int k = 0; k < 4; k++) sb.push_back(mk(8'h21 + 8'(k), k, k == 0, k == 3));
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        bus_a.I0 = 8'h99; bus_a.I1 = 8'h98; bus_a.I2 = 8'h97; bus_a.I3 = 8'h96;
      end else if (k == 1) begin
        bus_a.I0 = 8'h21; bus_a.I1 = 8'h22; bus_a.I2 = 8'h23; bus_a.I3 = 8'h24;
      end else if (k == 4) begin
        bus_a.load = 1'b0;
        bus_a.I0 = 8'h77; bus_a.I1 = 8'h78; bus_a.I2 = 8'h79; bus_a.I3 = 8'h7A;
      end
      @(negedge clk);
      total_cnt++;
      if (sb.size() == 0) $display("FAIL back_to_back k=%0d scoreboard empty", k);
      else begin
        e = sb.pop_front();
        want = {1'b1, e.y, e.sel, e.sync, e.ready};
        got  = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
        if (got !== want) $display("FAIL back_to_back k=%0d got %h want %h", k, got, want);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h1) $display("FAIL back_to_back_idle got %h want %h", got, 13'h1);
    else pass_cnt++;
  endtask

  task automatic test_slot_hold3();
    exp_t e;
    logic [12:0] got, want;
    @(posedge clk); #1;
    bus_b.I0 = 8'hB0; bus_b.I1 = 8'hB1; bus_b.I2 = 8'hB2; bus_b.I3 = 8'hB3;
    bus_b.load = 1'b1;
    for (int c = 0; c < 12; c++) sb.push_back(mk(8'hB0 + 8'(c / 3), c / 3, c == 0, c == 11));
    @(posedge clk); #1;
    bus_b.load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        bus_b.load = 1'b1;
        bus_b.I0 = 8'hEE; bus_b.I1 = 8'hEE; bus_b.I2 = 8'hEE; bus_b.I3 = 8'hEE;
      end else if (c == 5) begin
        bus_b.load = 1'b0;
      end
      @(negedge clk);
      total_cnt++;
      if (sb.size() == 0) $display("FAIL slot_hold3 c=%0d scoreboard empty", c);
      else begin
        e = sb.pop_front();
        want = {1'b1, e.y, e.sel, e.sync, e.ready};
        got  = {bus_b.valid, bus_b.Y, bus_b.S0, bus_b.S1, bus_b.sync, bus_b.ready};
        if (got !== want) $display("FAIL slot_hold3 c=%0d got %h want %h", c, got, want);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    got = {bus_b.valid, bus_b.Y, bus_b.S0, bus_b.S1, bus_b.sync, bus_b.ready};
    total_cnt++;
    if (got !== 13'h1) $display("FAIL slot_hold3_idle got %h want %h", got, 13'h1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] got, want;
    @(posedge clk); #1;
    bus_a.I0 = 8'h41; bus_a.I1 = 8'h42; bus_a.I2 = 8'h43; bus_a.I3 = 8'h44;
    bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    want = {1'b1, 8'h43, 2'b10, 1'b0, 1'b0};
    got  = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== want) $display("FAIL abort_slot2 got %h want %h", got, want);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h0) $display("FAIL abort_outputs got %h want %h", got, 13'h0);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    got = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== 13'h1) $display("FAIL abort_release got %h want %h", got, 13'h1);
    else pass_cnt++;
    bus_a.I0 = 8'h51; bus_a.I1 = 8'h52; bus_a.I2 = 8'h53; bus_a.I3 = 8'h54;
    bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    @(negedge clk);
    want = {1'b1, 8'h51, 2'b00, 1'b1, 1'b0};
    got  = {bus_a.valid, bus_a.Y, bus_a.S0, bus_a.S1, bus_a.sync, bus_a.ready};
    total_cnt++;
    if (got !== want) $display("FAIL abort_restart got %h want %h", got, want);
    else pass_cnt++;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.load = 1'b0; bus_b.load = 1'b0; bus_c.load = 1'b0;
    bus_a.I0 = '0; bus_a.I1 = '0; bus_a.I2 = '0; bus_a.I3 = '0;
    bus_b.I0 = '0; bus_b.I1 = '0; bus_b.I2 = '0; bus_b.I3 = '0;
    bus_c.I0 = '0; bus_c.I1 = '0; bus_c.I2 = '0; bus_c.I3 = '0;
    test_reset();
    test_single_frame();
    test_loopback();
    test_back_to_back();
    test_slot_hold3();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
